// File: rtl/ascii_to_hex.sv
// rtl/ascii_to_hex.sv - decodes a line of ASCII hex digits into a right-aligned packed word
module ascii_to_hex #(
    parameter int NIBBLES = 8,
    parameter int CNT_W   = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   En,
    input  logic [7:0]             ASCIIIn,
    input  logic                   ASCIIValid,
    input  logic                   HexAck,
    output logic [4*NIBBLES-1:0]   HexOut,
    output logic [CNT_W-1:0]       HexCount,
    output logic                   HexReady,
    output logic                   BadChar,
    output logic                   LenErr,
    output logic                   Overrun
);

    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DISCARD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     hex_out_q, hex_out_d;
    logic [CNT_W-1:0] hex_count_q, hex_count_d;
    logic             hex_ready_q, hex_ready_d;
    logic             bad_char_q, bad_char_d;
    logic             len_err_q, len_err_d;
    logic             overrun_q, overrun_d;

    logic             rx;
    logic             is_digit;
    logic             is_term;
    logic [3:0]       nibble;
    logic             start_line;

    // A character only counts when the block is enabled and the receiver strobes.
    assign rx = En & ASCIIValid;

    // Classify the incoming character and decode its nibble value.
    always_comb begin
        is_digit = 1'b0;
        is_term  = 1'b0;
        nibble   = 4'h0;
        if (ASCIIIn >= 8'h30 && ASCIIIn <= 8'h39) begin
            is_digit = 1'b1;
            nibble   = 4'(ASCIIIn - 8'h30);
        end else if (ASCIIIn >= 8'h41 && ASCIIIn <= 8'h46) begin
            is_digit = 1'b1;
            nibble   = 4'(ASCIIIn - 8'h37);
        end else if (ASCIIIn >= 8'h61 && ASCIIIn <= 8'h66) begin
            is_digit = 1'b1;
            nibble   = 4'(ASCIIIn - 8'h57);
        end else if (ASCIIIn == 8'h0D || ASCIIIn == 8'h0A) begin
            is_term  = 1'b1;
        end
    end

    // Next-state logic; an acknowledged DONE behaves exactly like IDLE for the same-cycle character.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        hex_out_d   = hex_out_q;
        hex_count_d = hex_count_q;
        hex_ready_d = hex_ready_q;
        bad_char_d  = 1'b0;
        len_err_d   = 1'b0;
        overrun_d   = 1'b0;
        start_line  = 1'b0;

        case (state_q)
            IDLE: begin
                start_line = rx;
            end
            COLLECT: begin
                if (rx) begin
                    if (is_digit) begin
                        if (cnt_q < CNT_W'(NIBBLES)) begin
                            acc_d = (acc_q << 4) | {{(W-4){1'b0}}, nibble};
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            len_err_d = 1'b1;
                            state_d   = DISCARD;
                        end
                    end else if (is_term) begin
                        hex_out_d   = acc_q;
                        hex_count_d = cnt_q;
                        hex_ready_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        bad_char_d = 1'b1;
                        state_d    = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (rx && is_term) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (HexAck) begin
                    hex_ready_d = 1'b0;
                    state_d     = IDLE;
                    start_line  = rx;
                end else if (rx) begin
                    if (is_digit) begin
                        overrun_d = 1'b1;
                    end else if (!is_term) begin
                        bad_char_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_line) begin
            if (is_digit) begin
                acc_d   = {{(W-4){1'b0}}, nibble};
                cnt_d   = CNT_W'(1);
                state_d = COLLECT;
            end else if (!is_term) begin
                bad_char_d = 1'b1;
            end
        end
    end

    // State and output registers; reset drops any partial word.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            hex_out_q   <= '0;
            hex_count_q <= '0;
            hex_ready_q <= 1'b0;
            bad_char_q  <= 1'b0;
            len_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            hex_out_q   <= hex_out_d;
            hex_count_q <= hex_count_d;
            hex_ready_q <= hex_ready_d;
            bad_char_q  <= bad_char_d;
            len_err_q   <= len_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign HexOut   = hex_out_q;
    assign HexCount = hex_count_q;
    assign HexReady = hex_ready_q;
    assign BadChar  = bad_char_q;
    assign LenErr   = len_err_q;
    assign Overrun  = overrun_q;

endmodule

// File: tb/tb_ascii_to_hex.sv
// tb/tb_ascii_to_hex.sv - directed self-checking bench for ascii_to_hex
module tb_ascii_to_hex;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        En;
    logic [7:0]  ASCIIIn;
    logic        ASCIIValid;
    logic        HexAck;
    logic [31:0] HexOut;
    logic [3:0]  HexCount;
    logic        HexReady;
    logic        BadChar;
    logic        LenErr;
    logic        Overrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int bad_seen = 0;
    int len_seen = 0;
    int ovr_seen = 0;

    ascii_to_hex #(.NIBBLES(8), .CNT_W(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .En         (En),
        .ASCIIIn    (ASCIIIn),
        .ASCIIValid (ASCIIValid),
        .HexAck     (HexAck),
        .HexOut     (HexOut),
        .HexCount   (HexCount),
        .HexReady   (HexReady),
        .BadChar    (BadChar),
        .LenErr     (LenErr),
        .Overrun    (Overrun)
    );

    always #5 Clk = ~Clk;

    // Count flag pulses a few ns after each rising edge; a one-cycle pulse counts once.
    always begin
        @(posedge Clk);
        #3;
        if (BadChar) bad_seen++;
        if (LenErr)  len_seen++;
        if (Overrun) ovr_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge Clk);
        ASCIIIn    = c;
        ASCIIValid = 1'b1;
        @(negedge Clk);
        ASCIIValid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic ack();
        @(negedge Clk);
        HexAck = 1'b1;
        @(negedge Clk);
        HexAck = 1'b0;
    endtask

    task automatic clear_flags();
        bad_seen = 0;
        len_seen = 0;
        ovr_seen = 0;
    endtask

    initial begin
        Reset      = 1'b1;
        En         = 1'b1;
        ASCIIIn    = 8'h00;
        ASCIIValid = 1'b0;
        HexAck     = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_hexout", HexOut, 32'h0);
        check("rst_count", 32'(HexCount), 32'd0);
        check("rst_ready", 32'(HexReady), 32'd0);
        check("rst_flags", {29'd0, BadChar, LenErr, Overrun}, 32'd0);
        Reset = 1'b0;
        clear_flags();

        // 1: full-width mixed-case word
        send_str("1a2B3c4D");
        check("t1_ready_before_cr", 32'(HexReady), 32'd0);
        send(8'h0D);
        check("t1_ready", 32'(HexReady), 32'd1);
        check("t1_hexout", HexOut, 32'h1A2B3C4D);
        check("t1_count", 32'(HexCount), 32'd8);
        repeat (3) @(negedge Clk);
        check("t1_hold_ready", 32'(HexReady), 32'd1);
        check("t1_hold_out", HexOut, 32'h1A2B3C4D);
        ack();
        check("t1_ready_drop", 32'(HexReady), 32'd0);

        // 2: LF terminator, CR in DONE ignored, lone CR after ack gives nothing
        clear_flags();
        send_str("ff");
        send(8'h0A);
        check("t2_hexout", HexOut, 32'h000000FF);
        check("t2_count", 32'(HexCount), 32'd2);
        send(8'h0D);
        check("t2_cr_in_done_ready", 32'(HexReady), 32'd1);
        check("t2_cr_in_done_out", HexOut, 32'h000000FF);
        ack();
        send(8'h0D);
        repeat (2) @(negedge Clk);
        check("t2_lone_cr_ready", 32'(HexReady), 32'd0);
        check("t2_no_flags", 32'(bad_seen + len_seen + ovr_seen), 32'd0);

        // 3: bad character discards the line
        clear_flags();
        send_str("12g4");
        send(8'h0D);
        repeat (2) @(negedge Clk);
        check("t3_badchar_pulses", 32'(bad_seen), 32'd1);
        check("t3_no_ready", 32'(HexReady), 32'd0);
        send_str("7");
        send(8'h0D);
        check("t3_hexout", HexOut, 32'h00000007);
        check("t3_count", 32'(HexCount), 32'd1);
        ack();

        // 4: nine digits overflow the line
        clear_flags();
        send_str("123456789");
        send(8'h0D);
        repeat (2) @(negedge Clk);
        check("t4_lenerr_pulses", 32'(len_seen), 32'd1);
        check("t4_no_badchar", 32'(bad_seen), 32'd0);
        check("t4_no_ready", 32'(HexReady), 32'd0);
        send_str("abc");
        send(8'h0D);
        check("t4_hexout", HexOut, 32'h00000ABC);
        check("t4_count", 32'(HexCount), 32'd3);

        // 5: digit while pending raises Overrun; ack with a digit starts a new word
        clear_flags();
        send(8'h35);
        check("t5_overrun_pulses", 32'(ovr_seen), 32'd1);
        check("t5_hexout_held", HexOut, 32'h00000ABC);
        check("t5_ready_held", 32'(HexReady), 32'd1);
        @(negedge Clk);
        ASCIIIn    = 8'h33;
        ASCIIValid = 1'b1;
        HexAck     = 1'b1;
        @(negedge Clk);
        ASCIIValid = 1'b0;
        HexAck     = 1'b0;
        check("t5_ready_after_ack", 32'(HexReady), 32'd0);
        send(8'h0D);
        check("t5_hexout_new", HexOut, 32'h00000003);
        check("t5_count_new", 32'(HexCount), 32'd1);
        check("t5_overrun_once", 32'(ovr_seen), 32'd1);
        ack();

        // En low: characters are ignored
        clear_flags();
        En = 1'b0;
        send(8'h39);
        send(8'h0D);
        En = 1'b1;
        send(8'h0D);
        repeat (2) @(negedge Clk);
        check("en_low_no_ready", 32'(HexReady), 32'd0);
        check("en_low_hexout_held", HexOut, 32'h00000003);

        // 6: asynchronous reset mid-line
        send_str("abc");
        #2;
        Reset = 1'b1;
        #1;
        check("t6_async_hexout", HexOut, 32'h0);
        check("t6_async_count", 32'(HexCount), 32'd0);
        check("t6_async_ready", 32'(HexReady), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        send_str("1");
        send(8'h0D);
        check("t6_hexout", HexOut, 32'h00000001);
        check("t6_count", 32'(HexCount), 32'd1);
        check("t6_ready", 32'(HexReady), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ascii_to_hex.md
Name: ascii_to_hex

Overview:
- Receive-side counterpart of the hex-to-ASCII transmit path.
- Accepts ASCII characters from the UART receiver one strobe at a time and decodes hex digits into 4-bit nibbles.
- Packs the nibbles MSB-first into a word and delivers it to the SHA256 input loader when a line terminator (CR or LF) arrives.
- Rejects malformed lines and reports the reason with one-cycle flags.

Parameters:
- NIBBLES, default 8: maximum hex digits per line. Word width = 4*NIBBLES.
- CNT_W, default 4: width of HexCount. Must satisfy 2**CNT_W > NIBBLES.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- En  input  1  enable. When low, ASCIIValid is ignored and all state holds.
- ASCIIIn  input  8  received character; sampled only when ASCIIValid=1.
- ASCIIValid  input  1  one-cycle strobe from the UART receiver.
- HexAck  input  1  consumer has taken HexOut; meaningful only while HexReady=1.
- HexOut  output  4*NIBBLES  assembled word, right-aligned, upper unused nibbles zero.
- HexCount  output  CNT_W  number of digits in HexOut; valid while HexReady=1.
- HexReady  output  1  level signal; high from word completion until acknowledged.
- BadChar  output  1  one-cycle pulse: a non-hex, non-terminator character was received.
- LenErr  output  1  one-cycle pulse: more than NIBBLES digits on one line.
- Overrun  output  1  one-cycle pulse: a hex digit arrived while a word was waiting for HexAck.

Behaviour:
- Reset (asynchronous, any state): HexOut=0, HexCount=0, HexReady=0, BadChar=0, LenErr=0, Overrun=0, state=IDLE, accumulator=0. Any partial word is lost.
- Character classes:
  - Digit: 0x30-0x39 decodes to 0-9; 0x41-0x46 and 0x61-0x66 decode to 10-15.
  - Terminator: 0x0D (CR) or 0x0A (LF).
  - Every other code is invalid.
- A character is "received" only on a cycle with En=1 and ASCIIValid=1. Flags are registered and are high for exactly the cycle after that edge.
- States:
  - IDLE:
    - Digit: acc = zero-extended nibble, cnt=1, go to COLLECT.
    - Terminator: ignored, so empty lines and the second character of a CRLF pair are harmless.
    - Invalid: BadChar pulse, stay in IDLE.
  - COLLECT:
    - Digit with cnt<NIBBLES: acc = (acc<<4)|nibble, truncated to 4*NIBBLES bits; cnt+1.
    - Digit with cnt=NIBBLES: LenErr pulse, go to DISCARD.
    - Invalid: BadChar pulse, go to DISCARD.
    - Terminator: HexOut=acc, HexCount=cnt, HexReady=1, go to DONE. HexReady rises on the same edge that samples the terminator.
  - DISCARD:
    - Every character except a terminator is dropped with no further flags.
    - Terminator: go to IDLE; acc and cnt are cleared.
    - No word is ever delivered from a discarded line.
  - DONE:
    - HexOut and HexCount are held stable.
    - HexAck=1: HexReady=0 on the next edge, go to IDLE.
    - Terminator received without HexAck: ignored.
    - Digit received without HexAck: dropped, Overrun pulse, HexOut unchanged.
    - Invalid character received without HexAck: dropped, BadChar pulse.
    - HexAck and a received character in the same cycle: the ack takes effect, and the character is processed exactly as IDLE would process it (a digit starts a new word with cnt=1). No Overrun is raised.
- HexAck outside DONE: ignored.
- En=0: no state change; HexReady and HexOut hold. HexAck is still honoured in DONE.
- Throughput: one character per cycle sustained, with no stall back-pressure to the UART.

Test Plan:
1. NIBBLES=8; send "1a2B3c4D" then CR → HexReady=1 after the CR edge; HexOut=0x1A2B3C4D, HexCount=8; both hold until HexAck, and HexReady drops the following cycle.
2. Send "ff", LF, then CR while in DONE → HexOut=0x000000FF, HexCount=2; the CR is ignored with no flags; after HexAck a lone CR produces no output.
3. Send "12g4" then CR → BadChar pulses once on 'g'; HexReady stays 0. Then send "7" then CR → HexOut=0x00000007, HexCount=1.
4. Send "123456789" then CR → LenErr pulses once on '9'; no HexReady. The next line "abc" then CR delivers 0x00000ABC.
5. With a word pending, send '5' without ack → Overrun pulses and HexOut is unchanged. Then assert HexAck in the same cycle as '3' followed by CR → new word 0x00000003; Overrun stays 0.
6. Assert Reset after "abc" mid-COLLECT (asynchronous, between edges) → all outputs 0 immediately. Then send "1" then CR → HexOut=0x00000001, HexCount=1.
